rename_unit: RTL and testbench

Register-rename stage that sits directly upstream of the reorder buffer. It maps decoded architectural operands to physical registers through a register alias table (RAT) and allocates destination registers from a circular free list. It presents P_rd_new and P_rd_old to the ROB dispatch port, and consumes the ROB's commit and rollback outputs to recycle registers and repair the RAT after a mispredict.

---
 rtl/rename_unit.sv | 117 +++++++++++
 tb/tb_rename_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Register rename stage: RAT lookup plus circular free-list allocation ahead of the ROB.
// Commits recycle old mappings at the tail; rollbacks repair the RAT and rewind the head.
module rename_unit #(
  parameter int NUM_AREG = 64,
  parameter int NUM_PREG = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_valid,
  input  logic       ID_rd_en,
  input  logic [5:0] ID_A_rs1,
  input  logic [5:0] ID_A_rs2,
  input  logic [5:0] ID_A_rd,
  output logic       ID_ready,
  input  logic       ROB_ready,
  input  logic       stall,
  output logic       DC_valid,
  output logic [6:0] DC_P_rs1,
  output logic [6:0] DC_P_rs2,
  output logic [6:0] DC_P_rd_new,
  output logic [6:0] DC_P_rd_old,
  output logic [5:0] DC_A_rd,
  input  logic       commit_wb_en,
  input  logic [6:0] commit_P_rd_old,
  input  logic       rollback_en_0,
  input  logic [5:0] rollback_A_rd_0,
  input  logic [6:0] rollback_P_rd_old_0,
  input  logic [6:0] rollback_P_rd_new_0,
  input  logic       rollback_en_1,
  input  logic [5:0] rollback_A_rd_1,
  input  logic [6:0] rollback_P_rd_old_1,
  input  logic [6:0] rollback_P_rd_new_1,
  output logic [6:0] fl_count
);

  localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
  localparam logic [6:0] FL_FULL = 7'(FL_DEPTH);

  logic [6:0] rat [NUM_AREG];
  logic [6:0] fl  [FL_DEPTH];
  logic [5:0] head;
  logic [5:0] tail;

  logic       need_rd;
  logic       fire;
  logic       alloc;
  logic       push;
  logic       rb_ret0;
  logic       rb_ret1;
  logic [1:0] rb_n;
  logic [5:0] lifo_idx0;
  logic [5:0] lifo_idx1;

  assign need_rd  = ID_rd_en && (ID_A_rd != 6'd0);
  assign ID_ready = !stall && ROB_ready && (!need_rd || fl_count != 7'd0);
  assign fire     = ID_valid && ID_ready;
  assign DC_valid = fire;
  assign alloc    = fire && need_rd;
  assign push     = commit_wb_en && (commit_P_rd_old != 7'd0);

  assign DC_P_rs1    = rat[ID_A_rs1];
  assign DC_P_rs2    = rat[ID_A_rs2];
  assign DC_P_rd_old = need_rd ? rat[ID_A_rd] : 7'd0;
  assign DC_P_rd_new = need_rd ? fl[head] : 7'd0;
  assign DC_A_rd     = ID_A_rd;

  // Only slots that actually consumed a free-list entry give one back.
  assign rb_ret0 = rollback_en_0 && (rollback_P_rd_new_0 != 7'd0);
  assign rb_ret1 = rollback_en_1 && (rollback_P_rd_new_1 != 7'd0);
  assign rb_n    = {1'b0, rb_ret0} + {1'b0, rb_ret1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_AREG; i++) rat[i] <= 7'(i);
    end else if (alloc) begin
      rat[ID_A_rd] <= fl[head];
    end else begin
      // Slot 0 is younger; slot 1's later assignment wins on a shared A_rd.
      if (rollback_en_0 && rollback_A_rd_0 != 6'd0) rat[rollback_A_rd_0] <= rollback_P_rd_old_0;
      if (rollback_en_1 && rollback_A_rd_1 != 6'd0) rat[rollback_A_rd_1] <= rollback_P_rd_old_1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < FL_DEPTH; j++) fl[j] <= 7'(NUM_AREG + j);
    end else if (push) begin
      fl[tail] <= commit_P_rd_old;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= 6'd0;
      tail     <= 6'd0;
      fl_count <= FL_FULL;
    end else begin
      head     <= head + 6'(alloc) - {4'd0, rb_n};
      tail     <= tail + 6'(push);
      fl_count <= fl_count - 7'(alloc) + 7'(push) + {5'd0, rb_n};
    end
  end

  // Rollback returns registers in LIFO order; entries are not rewritten.
  assign lifo_idx0 = head - 6'd1;
  assign lifo_idx1 = head - 6'd1 - {5'd0, rb_ret0};

  a_rb_no_fire: assert property (@(posedge clk) disable iff (!rst)
    (rollback_en_0 || rollback_en_1) |-> !fire);
  a_lifo0: assert property (@(posedge clk) disable iff (!rst)
    rb_ret0 |-> (fl[lifo_idx0] == rollback_P_rd_new_0));
  a_lifo1: assert property (@(posedge clk) disable iff (!rst)
    rb_ret1 |-> (fl[lifo_idx1] == rollback_P_rd_new_1));
  a_push_full: assert property (@(posedge clk) disable iff (!rst)
    push |-> (fl_count != FL_FULL));

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: reference RAT/free-list model feeds a scoreboard queue
// checked at the falling edge, plus directed constant checks.
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ID_valid = 1'b0, ID_rd_en = 1'b0;
  logic [5:0] ID_A_rs1 = '0, ID_A_rs2 = '0, ID_A_rd = '0;
  logic       ID_ready;
  logic       ROB_ready = 1'b1, stall = 1'b0;
  logic       DC_valid;
  logic [6:0] DC_P_rs1, DC_P_rs2, DC_P_rd_new, DC_P_rd_old;
  logic [5:0] DC_A_rd;
  logic       commit_wb_en = 1'b0;
  logic [6:0] commit_P_rd_old = '0;
  logic       rollback_en_0 = 1'b0, rollback_en_1 = 1'b0;
  logic [5:0] rollback_A_rd_0 = '0, rollback_A_rd_1 = '0;
  logic [6:0] rollback_P_rd_old_0 = '0, rollback_P_rd_new_0 = '0;
  logic [6:0] rollback_P_rd_old_1 = '0, rollback_P_rd_new_1 = '0;
  logic [6:0] fl_count;

  rename_unit dut (
    .clk(clk), .rst(rst),
    .ID_valid(ID_valid), .ID_rd_en(ID_rd_en),
    .ID_A_rs1(ID_A_rs1), .ID_A_rs2(ID_A_rs2), .ID_A_rd(ID_A_rd),
    .ID_ready(ID_ready), .ROB_ready(ROB_ready), .stall(stall),
    .DC_valid(DC_valid), .DC_P_rs1(DC_P_rs1), .DC_P_rs2(DC_P_rs2),
    .DC_P_rd_new(DC_P_rd_new), .DC_P_rd_old(DC_P_rd_old), .DC_A_rd(DC_A_rd),
    .commit_wb_en(commit_wb_en), .commit_P_rd_old(commit_P_rd_old),
    .rollback_en_0(rollback_en_0), .rollback_A_rd_0(rollback_A_rd_0),
    .rollback_P_rd_old_0(rollback_P_rd_old_0), .rollback_P_rd_new_0(rollback_P_rd_new_0),
    .rollback_en_1(rollback_en_1), .rollback_A_rd_1(rollback_A_rd_1),
    .rollback_P_rd_old_1(rollback_P_rd_old_1), .rollback_P_rd_new_1(rollback_P_rd_new_1),
    .fl_count(fl_count)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int ready, valid, rs1, rs2, pnew, pold, cnt, ard;
  } exp_t;
  exp_t sb[$];
  int   retire[$];

  int m_rat[64];
  int m_fl[64];
  int m_head, m_tail, m_cnt;
  int obs_ready, obs_valid, obs_rs1, obs_new, obs_old;

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_rat[i] = i;
      m_fl[i]  = 64 + i;
    end
    m_head = 0;
    m_tail = 0;
    m_cnt  = 64;
    retire.delete();
  endtask

  task automatic cycle(input bit v, input bit rd_en, input int rs1, input int rs2, input int rd,
                       input bit cm, input int cmp, input bit rob);
    exp_t e, g;
    bit   need;
    ID_valid = v; ID_rd_en = rd_en;
    ID_A_rs1 = 6'(rs1); ID_A_rs2 = 6'(rs2); ID_A_rd = 6'(rd);
    commit_wb_en = cm; commit_P_rd_old = 7'(cmp);
    ROB_ready = rob; stall = 1'b0;
    need    = rd_en && (rd != 0);
    e.ready = (rob && (!need || m_cnt != 0)) ? 1 : 0;
    e.valid = (v && e.ready != 0) ? 1 : 0;
    e.rs1   = m_rat[rs1];
    e.rs2   = m_rat[rs2];
    e.pnew  = need ? m_fl[m_head] : 0;
    e.pold  = need ? m_rat[rd] : 0;
    e.cnt   = m_cnt;
    e.ard   = rd;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    obs_ready = int'(ID_ready); obs_valid = int'(DC_valid);
    obs_rs1 = int'(DC_P_rs1); obs_new = int'(DC_P_rd_new); obs_old = int'(DC_P_rd_old);
    chk("id_ready", ID_ready, g.ready);
    chk("dc_valid", DC_valid, g.valid);
    chk("p_rs1", DC_P_rs1, g.rs1);
    chk("p_rs2", DC_P_rs2, g.rs2);
    chk("p_rd_new", DC_P_rd_new, g.pnew);
    chk("p_rd_old", DC_P_rd_old, g.pold);
    chk("a_rd", DC_A_rd, g.ard);
    chk("fl_count", fl_count, g.cnt);
    @(posedge clk);
    if (g.valid != 0 && need) begin
      retire.push_back(g.pold);
      m_rat[rd] = g.pnew;
      m_head = (m_head + 1) % 64;
      m_cnt--;
    end
    if (cm && cmp != 0) begin
      m_fl[m_tail] = cmp;
      m_tail = (m_tail + 1) % 64;
      m_cnt++;
    end
    #1;
  endtask

  task automatic rollback(input bit e0, input int a0, input int o0, input int n0,
                          input bit e1, input int a1, input int o1, input int n1);
    ID_valid = 1'b1; ID_rd_en = 1'b1; ID_A_rd = 6'd4;
    commit_wb_en = 1'b0; stall = 1'b1;
    rollback_en_0 = e0; rollback_A_rd_0 = 6'(a0);
    rollback_P_rd_old_0 = 7'(o0); rollback_P_rd_new_0 = 7'(n0);
    rollback_en_1 = e1; rollback_A_rd_1 = 6'(a1);
    rollback_P_rd_old_1 = 7'(o1); rollback_P_rd_new_1 = 7'(n1);
    @(negedge clk);
    chk("rb_id_ready", ID_ready, 0);
    chk("rb_dc_valid", DC_valid, 0);
    @(posedge clk);
    if (e0) m_rat[a0] = o0;
    if (e1) m_rat[a1] = o1;
    if (e0 && n0 != 0) begin m_head = (m_head + 63) % 64; m_cnt++; end
    if (e1 && n1 != 0) begin m_head = (m_head + 63) % 64; m_cnt++; end
    #1;
    rollback_en_0 = 1'b0; rollback_en_1 = 1'b0; stall = 1'b0; ID_valid = 1'b0;
  endtask

  task automatic async_reset_check();
    ID_valid = 1'b0; commit_wb_en = 1'b0;
    ID_A_rs1 = 6'd1; ID_A_rs2 = 6'd10;
    rst = 1'b0;
    #1;
    chk("rst_fl_count", fl_count, 64);
    chk("rst_rat_rs1", DC_P_rs1, 1);
    chk("rst_rat_rs2", DC_P_rs2, 10);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_reset();
    #12 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("init_id_ready", ID_ready, 1);
    chk("init_dc_valid", DC_valid, 0);
    chk("init_fl_count", fl_count, 64);
    @(posedge clk); #1;

    // First rename, then dependent read of the new mapping
    cycle(1, 1, 5, 0, 5, 0, 0, 1);
    chk("t1_new", obs_new, 64);
    chk("t1_old", obs_old, 5);
    chk("t1_rs1", obs_rs1, 5);
    cycle(1, 0, 5, 0, 0, 0, 0, 1);
    chk("t1_dep_rs1", obs_rs1, 64);
    chk("t1_fl_count", fl_count, 63);

    // x0 destination is never renamed
    cycle(1, 1, 0, 0, 0, 0, 0, 1);
    chk("x0_new", obs_new, 0);
    chk("x0_old", obs_old, 0);
    chk("x0_fl_count", fl_count, 63);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    chk("x0_rat", obs_rs1, 0);

    // Drain the free list completely
    for (int i = 0; i < 63; i++) cycle(1, 1, i % 64, (i * 7) % 64, 1 + (i % 63), 0, 0, 1);
    chk("empty_fl_count", fl_count, 0);
    cycle(1, 1, 2, 3, 7, 0, 0, 1);
    chk("empty_ready", obs_ready, 0);
    chk("empty_valid", obs_valid, 0);
    cycle(1, 0, 2, 3, 7, 0, 0, 1);
    chk("empty_nodest_valid", obs_valid, 1);
    cycle(0, 0, 0, 0, 0, 1, 5, 1);
    cycle(1, 1, 2, 3, 9, 0, 0, 1);
    chk("freed_ready", obs_ready, 1);
    chk("freed_new", obs_new, 5);

    async_reset_check();

    // Two renames of A3, then roll both back
    cycle(1, 1, 0, 0, 3, 0, 0, 1);
    cycle(1, 1, 3, 0, 3, 0, 0, 1);
    chk("rb_pre_new", obs_new, 65);
    chk("rb_pre_old", obs_old, 64);
    rollback(1, 3, 64, 65, 1, 3, 3, 64);
    retire.delete();
    chk("rb_fl_count", fl_count, 64);
    cycle(1, 1, 3, 0, 3, 0, 0, 1);
    chk("rb_rat3", obs_rs1, 3);
    chk("rb_head_new", obs_new, 64);

    // Fire and commit in the same cycle
    cycle(1, 1, 0, 0, 10, 1, 7, 1);
    chk("fc_fl_count", fl_count, 63);
    cycle(1, 1, 10, 0, 11, 0, 0, 1);
    chk("fc_head_new", obs_new, 66);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      bit v, rde, cm, rob;
      int cmp;
      v   = ($urandom_range(0, 3) != 0);
      rde = ($urandom_range(0, 1) != 0);
      rob = ($urandom_range(0, 7) != 0);
      cm  = (retire.size() > 0) && (m_cnt < 64) && ($urandom_range(0, 1) != 0);
      cmp = cm ? retire.pop_front() : 0;
      cycle(v, rde, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 63)), cm, cmp, rob);
    end

    // Ten allocations, then reset without a clock edge
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, i + 1, 0, 0, 1);
    async_reset_check();
    cycle(1, 1, 1, 2, 1, 0, 0, 1);
    chk("post_rst_new", obs_new, 64);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
